addres_wr_generator: RTL and testbench

//  Write-side address generator for one FFT butterfly stage (the writer counterpart of the stage read generators).

---
 rtl/fft_pkg.sv | 17 +
 rtl/addres_wr_generator_if.sv | 28 ++
 rtl/fft_bf_addr_map.sv | 29 ++
 rtl/addres_wr_generator.sv | 93 +++++++++
 tb/tb_addres_wr_generator.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and the stage address-generator state encoding.
// Used by both the read-side and write-side stage address generators.
package fft_pkg;

    localparam int FFT_N    = 16;  // FFT length, power of two
    localparam int FFT_SIZE = 4;   // log2(FFT_N), address width
    localparam int STG_W    = 3;   // stage index width, 2**STG_W >= FFT_SIZE

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_WR_TOP = 3'd2,
        S_WR_BOT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/addres_wr_generator_if.sv
// Handshake and memory-write bus between the butterfly unit / sequencer
// (master) and the write address generator (slave).
interface addres_wr_generator_if #(
    parameter int SIZE  = fft_pkg::FFT_SIZE,
    parameter int STG_W = fft_pkg::STG_W
) ();

    logic             start_stage;
    logic [STG_W-1:0] stage;
    logic             wr_valid;
    logic             wr_ready;
    logic             en_wr;
    logic [SIZE-1:0]  wr_ptr;
    logic             wr_sel;
    logic             busy;
    logic             stage_done;

    modport master (
        output start_stage, stage, wr_valid,
        input  wr_ready, en_wr, wr_ptr, wr_sel, busy, stage_done
    );

    modport slave (
        input  start_stage, stage, wr_valid,
        output wr_ready, en_wr, wr_ptr, wr_sel, busy, stage_done
    );

endinterface

// File: rtl/fft_bf_addr_map.sv
// In-place radix-2 butterfly address map: butterfly index k and stage
// select the top/bottom operand addresses. Purely combinational.
module fft_bf_addr_map #(
    parameter int SIZE  = fft_pkg::FFT_SIZE,
    parameter int STG_W = fft_pkg::STG_W
) (
    input  logic [SIZE-2:0]  i_k,
    input  logic [STG_W-1:0] i_stage,
    output logic [SIZE-1:0]  o_top,
    output logic [SIZE-1:0]  o_bot
);

    logic [SIZE-1:0] w_k;
    logic [SIZE-1:0] w_span;
    logic [SIZE-1:0] w_hi;
    logic [SIZE-1:0] w_lo;

    // Insert a zero at bit 'stage' of k to get top; bottom is top + span.
    // Stage is clamped upstream, so top has bit 'stage' clear and bot never wraps.
    always_comb begin
        w_k    = {1'b0, i_k};
        w_span = SIZE'(1) << i_stage;
        w_hi   = ((w_k >> i_stage) << i_stage) << 1;
        w_lo   = w_k & (w_span - SIZE'(1));
        o_top  = w_hi | w_lo;
        o_bot  = o_top + w_span;
    end

endmodule

// File: rtl/addres_wr_generator.sv
// Write-side address generator for one FFT butterfly stage.
// Takes one result pair per handshake, writes top then bottom at the
// in-place addresses, and pulses stage_done after the last pair.
module addres_wr_generator #(
    parameter int N     = fft_pkg::FFT_N,
    parameter int SIZE  = fft_pkg::FFT_SIZE,
    parameter int STG_W = fft_pkg::STG_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addres_wr_generator_if.slave bus
);

    import fft_pkg::*;

    localparam logic [SIZE-2:0] LAST_K = (SIZE-1)'(N/2 - 1);

    state_t           r_state;
    state_t           w_next;
    logic [SIZE-2:0]  r_k;
    logic [STG_W-1:0] r_stage;
    logic [STG_W-1:0] w_stage_in;
    logic [SIZE-1:0]  w_top;
    logic [SIZE-1:0]  w_bot;

    // Stages beyond the last real one behave as the last stage.
    assign w_stage_in = (int'(bus.stage) >= SIZE) ? STG_W'(SIZE-1) : bus.stage;

    fft_bf_addr_map #(
        .SIZE  (SIZE),
        .STG_W (STG_W)
    ) u_map (
        .i_k     (r_k),
        .i_stage (r_stage),
        .o_top   (w_top),
        .o_bot   (w_bot)
    );

    // State register plus butterfly counter and latched stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start_stage) begin
                r_stage <= w_stage_in;
                r_k     <= '0;
            end else if (r_state == S_WR_BOT) begin
                r_k <= r_k + (SIZE-1)'(1);
            end
        end
    end

    // Next-state: a start is only seen in IDLE, a pair only in WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start_stage) w_next = S_WAIT;
            S_WAIT:   if (bus.wr_valid)    w_next = S_WR_TOP;
            S_WR_TOP: w_next = S_WR_BOT;
            S_WR_BOT: w_next = (r_k == LAST_K) ? S_DONE : S_WAIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Registered outputs decoded from next state, so they line up with r_state.
    // r_k still holds the current pair in both write states (it steps leaving WR_BOT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_ready   <= 1'b0;
            bus.en_wr      <= 1'b0;
            bus.wr_ptr     <= '0;
            bus.wr_sel     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.stage_done <= 1'b0;
        end else begin
            bus.wr_ready   <= (w_next == S_WAIT);
            bus.en_wr      <= (w_next == S_WR_TOP) || (w_next == S_WR_BOT);
            bus.wr_sel     <= (w_next == S_WR_BOT);
            bus.busy       <= (w_next != S_IDLE);
            bus.stage_done <= (w_next == S_DONE);
            case (w_next)
                S_WR_TOP: bus.wr_ptr <= w_top;
                S_WR_BOT: bus.wr_ptr <= w_bot;
                default:  bus.wr_ptr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_addres_wr_generator.sv
// Self-checking bench for addres_wr_generator: randomized handshake gaps
// and stages against an address-enumeration reference model.
module tb_addres_wr_generator;

    localparam int N     = 16;
    localparam int SIZE  = 4;
    localparam int STG_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    addres_wr_generator_if #(.SIZE(SIZE), .STG_W(STG_W)) bus ();

    addres_wr_generator #(
        .N     (N),
        .SIZE  (SIZE),
        .STG_W (STG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;
    int wptr_q[$];
    int wsel_q[$];
    int exp_q[$];
    int done_cnt = 0;
    int viol = 0;

    // Write log: every enabled write, plus protocol observations.
    always @(negedge clk) begin
        if (bus.en_wr) begin
            wptr_q.push_back(int'(bus.wr_ptr));
            wsel_q.push_back(int'(bus.wr_sel));
        end
        if (bus.en_wr && bus.wr_ready) viol++;
        if (bus.stage_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: every address whose bit 'stage' is clear is a top operand,
    // its partner is address + 2**stage; pairs come out in ascending top order.
    task automatic build_exp(input int st);
        int eff;
        int span;
        eff = (st >= SIZE) ? SIZE - 1 : st;
        span = 1 << eff;
        exp_q.delete();
        for (int a = 0; a < N; a++) begin
            if (((a / span) % 2) == 0) begin
                exp_q.push_back(a);
                exp_q.push_back(a + span);
            end
        end
    endtask

    task automatic run_stage(input int st, input int max_gap, input int mid_pair, input int rst_pair);
        int d0;
        int tmo;
        build_exp(st);
        wptr_q.delete();
        wsel_q.delete();
        d0 = done_cnt;
        viol = 0;
        @(negedge clk);
        bus.start_stage = 1'b1;
        bus.stage = STG_W'(st);
        @(negedge clk);
        bus.start_stage = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        chk("ready_after_start", bus.wr_ready, 1);
        for (int p = 0; p < N/2; p++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            bus.wr_valid = 1'b1;
            if (p == mid_pair) begin
                bus.start_stage = 1'b1;
                bus.stage = '0;
            end
            tmo = 0;
            while (!bus.wr_ready && tmo < 50) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 50) begin
                chk("ready_timeout", 0, 1);
                bus.wr_valid = 1'b0;
                bus.start_stage = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.wr_valid = 1'b0;
            bus.start_stage = 1'b0;
            @(negedge clk);
            chk("top_en", bus.en_wr, 1);
            chk("top_sel", bus.wr_sel, 0);
            if (p == rst_pair) begin
                rst_n = 1'b0;
                #1;
                chk("rst_en_wr", bus.en_wr, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_wr_ptr", bus.wr_ptr, 0);
                chk("rst_ready", bus.wr_ready, 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                chk("rst_no_done", done_cnt - d0, 0);
                chk("rst_idle_busy", bus.busy, 0);
                return;
            end
            @(negedge clk);
            chk("bot_en", bus.en_wr, 1);
            chk("bot_sel", bus.wr_sel, 1);
            if (p != N/2 - 1) begin
                @(negedge clk);
                chk("ready_again", bus.wr_ready, 1);
            end else begin
                @(negedge clk);
                chk("done_pulse", bus.stage_done, 1);
                chk("done_busy", bus.busy, 1);
                chk("done_no_write", bus.en_wr, 0);
                chk("done_ready", bus.wr_ready, 0);
                // start in the DONE cycle must be ignored
                bus.start_stage = 1'b1;
                bus.stage = '0;
                @(posedge clk);
                #1;
                bus.start_stage = 1'b0;
                @(negedge clk);
                chk("idle_busy", bus.busy, 0);
                chk("idle_done_low", bus.stage_done, 0);
                @(negedge clk);
                chk("no_restart_busy", bus.busy, 0);
                chk("no_restart_ready", bus.wr_ready, 0);
            end
        end
        chk("n_writes", wptr_q.size(), N);
        for (int i = 0; i < N && i < wptr_q.size(); i++) begin
            chk($sformatf("ptr_s%0d_%0d", st, i), wptr_q[i], exp_q[i]);
            chk($sformatf("sel_s%0d_%0d", st, i), wsel_q[i], i % 2);
        end
        chk("done_count", done_cnt - d0, 1);
        chk("write_in_wait", viol, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start_stage = 1'b0;
        bus.stage = '0;
        bus.wr_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("inreset_en_wr", bus.en_wr, 0);
        chk("inreset_busy", bus.busy, 0);
        rst_n = 1'b1;
        // wr_valid in IDLE is not accepted
        bus.wr_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_en_wr", bus.en_wr, 0);
        chk("idle_wr_ready", bus.wr_ready, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_stage_done", bus.stage_done, 0);
        chk("idle_no_writes", wptr_q.size(), 0);
        bus.wr_valid = 1'b0;

        run_stage(0, 0, -1, -1);
        run_stage(2, 0, -1, -1);
        chk("s2_pair4_top", wptr_q[8], 8);
        chk("s2_pair4_bot", wptr_q[9], 12);
        run_stage(1, 5, -1, -1);
        chk("s1_k2_top", wptr_q[4], 4);
        chk("s1_k2_bot", wptr_q[5], 6);
        run_stage(3, 2, -1, -1);
        run_stage(5, 1, 3, -1);
        chk("s5_clamp_k1_bot", wptr_q[3], 9);
        run_stage(1, 0, -1, 3);
        run_stage(2, 2, -1, -1);
        repeat (4) run_stage(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)), -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
